rom_fetch: RTL and testbench
============================

# rom_fetch

Instruction fetch initiator for the byte-addressed instruction ROM. It keeps a program counter and issues one-word reads through the ROM's `addr`/`enable` port. Each returned 32-bit word is captured into a small instruction queue and presented to the decode stage over a valid/ready handshake. It also handles PC redirects (branches and jumps) and out-of-range fetch addresses.

## Interface

Parameters:
- `RESET_PC`, 0: PC loaded on reset; must be word-aligned.
- `MEM_BYTES`, 128: ROM size in bytes; the highest legal fetch address is `MEM_BYTES-4`.
- `QDEPTH`, 2: instruction queue depth; power of two, ≥2.

Ports:
- `clk`, input, 1: single clock; all state updates on posedge.
- `reset`, input, 1: synchronous, active-high.
- `rom_addr`, output, 32: ROM byte address; equals current PC.
- `rom_enable`, output, 1: ROM read strobe; ROM returns data one cycle later.
- `rom_data`, input, 32: ROM read word, `{b[a+3],b[a+2],b[a+1],b[a]}`.
- `redirect_valid`, input, 1: load new PC this cycle.
- `redirect_pc`, input, 32: redirect target.
- `instr_valid`, output, 1: queue head valid.
- `instr_data`, output, 32: queue head word.
- `instr_pc`, output, 32: byte address of the queue head word.
- `instr_ready`, input, 1: decode accepts the head this cycle.
- `fault`, output, 1: sticky fetch fault.

## Operation

- Reset state:
  - `pc=RESET_PC`; queue empty; no read in flight; state RUN.
  - `rom_enable=0`, `rom_addr=RESET_PC`, `instr_valid=0`, `instr_data=0`, `instr_pc=0`, `fault=0`.
- States:
  - **RUN**: issue reads.
  - **FAULT**: no reads issued; `fault=1`.
- Issue condition (RUN only): `count + inflight - pop < QDEPTH`, no redirect this cycle, and `pc` legal.
  - On issue: `rom_enable=1`, `rom_addr=pc`, and `pc <= pc+4`.
  - `rom_enable` and `rom_addr` are combinational from pc/state.
- Capture: in the cycle after an issue, `rom_data` is written to the queue tail together with its PC. Capture is lossless by construction.
- Dequeue (pop): when `instr_valid && instr_ready`, the head advances. Simultaneous push and pop are allowed, and count is unchanged.
- Redirect (highest priority below reset):
  - Clear the queue, discard any response arriving this cycle, and suppress issue this cycle.
  - `pc <= redirect_pc`; state becomes RUN and `fault` clears.
  - A pop in the same cycle is ignored, because the queue is cleared.
- Legality: `pc` is illegal if `pc > MEM_BYTES-4` or `pc[1:0] != 0`.
  - When RUN holds an illegal `pc`: move to FAULT on the next edge, and issue nothing.
  - Queued words remain deliverable.
  - FAULT is left only by redirect or reset.
- `reset` mid-operation: everything returns to the reset state at that edge. A response due in the following cycle is dropped.

## Timing

- Read latency: an issue in cycle T gives ROM data during T+1, which is captured at the end of T+1. `instr_valid` rises no earlier than T+2.
- After `reset` falls (cycle 0):
  - First issue in cycle 0.
  - First `instr_valid` in cycle 2.
- Throughput: with `instr_ready` held high, one instruction per cycle at `QDEPTH=2` (steady state is count=1, inflight=1).
- Backpressure: with `instr_ready=0`, issue stops once count+inflight reaches QDEPTH.
- Redirect: a redirect in cycle T gives an issue of `redirect_pc` in T+1 and the target's `instr_valid` in T+3.
- Fault detection: `fault` rises the cycle after `pc` first becomes illegal in RUN.

## Configuration

- `ROM_BOUNDS_CHECK_EN` defined: legality checking and the FAULT state operate as described above.
- `ROM_BOUNDS_CHECK_EN` undefined:
  - No FAULT state; `fault` is tied to 0.
  - `pc` increments modulo `MEM_BYTES`, wrapping `MEM_BYTES-4` to 0.
  - `redirect_pc` is masked to `{0, redirect_pc[log2(MEM_BYTES)-1:2], 2'b00}`.

## Test plan

ROM image is byte i = i for i<16 and 0 elsewhere.

1. **Streaming:** `reset` 1→0, `instr_ready=1` → `instr_valid` from cycle 2. Deliveries are (pc, data):
   - (0, 0x03020100)
   - (4, 0x07060504)
   - (8, 0x0B0A0908)
   - (12, 0x0F0E0D0C)
   - (16, 0x00000000)

   One delivery per cycle.
2. **Backpressure:** `instr_ready=0` from cycle 2 for 5 cycles → `rom_enable=0` once 2 words are held. After release, delivery resumes at pc 0, 4, 8… with no gaps or duplicates.
3. **Redirect while a read is in flight:** `redirect_pc=8` at cycle 3 → the next delivered word is (8, 0x0B0A0908) at cycle 6. Nothing from pc 4/12 appears afterwards.
4. **Redirect during pop:** `redirect_valid` and `instr_ready` both high while `instr_valid=1` → queue empty next cycle, and the next word comes from `redirect_pc`.
5. **Bounds, `ROM_BOUNDS_CHECK_EN` defined:**
   - Redirect to 124 → deliver (124, 0); `fault=1` when pc reaches 128; `rom_enable` stays 0.
   - Redirect to 6 → `fault=1`.
   - Redirect to 0 → `fault=0`, and streaming resumes.

   Without the macro, 124 is followed by (0, 0x03020100).
6. **Reset mid-stream:** assert `reset` for 1 cycle at cycle 5 → all outputs return to reset values, and the stream restarts at pc 0 with no stale word.

Source files
------------

// File: rtl/rom_fetch.sv
// rom_fetch: instruction fetch initiator; PC, one-cycle ROM reads, instruction queue with valid/ready output.
// Optional feature macro: ROM_BOUNDS_CHECK_EN (legality checking + sticky FAULT state);
// without it the PC wraps modulo MEM_BYTES and redirect targets are masked into range.
module rom_fetch #(
    parameter logic [31:0] RESET_PC  = 32'd0,
    parameter int          MEM_BYTES = 128,
    parameter int          QDEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] rom_addr,
    output logic        rom_enable,
    input  logic [31:0] rom_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    output logic        fault
);
    localparam int QW = $clog2(QDEPTH);
    localparam logic [31:0] LAST = 32'(MEM_BYTES - 4);

    logic [31:0] pc, ipc, pc_next, target;
    logic        inflight, run_ok, issue, pop;
    logic [QW-1:0] head, tail;
    logic [QW:0]   count;
    logic [QW+1:0] occ;
    logic [31:0]   qd [QDEPTH];
    logic [31:0]   qp [QDEPTH];

`ifdef ROM_BOUNDS_CHECK_EN
    localparam logic [0:0] RUN = 1'b0, FAULT = 1'b1;
    logic [0:0] state;
    assign run_ok  = state == RUN && pc <= LAST && pc[1:0] == 2'b00;
    assign fault   = state == FAULT;
    assign pc_next = pc + 32'd4;
    assign target  = redirect_pc;
    // an illegal pc in RUN parks the fetcher in FAULT until redirect or reset
    always_ff @(posedge clk)
        if (reset || redirect_valid) state <= RUN;
        else if (state == RUN && !run_ok) state <= FAULT;
`else
    assign run_ok  = 1'b1;
    assign fault   = 1'b0;
    assign pc_next = pc == LAST ? 32'd0 : pc + 32'd4;
    assign target  = redirect_pc & LAST;
`endif

    assign pop         = instr_valid && instr_ready;
    assign occ         = {1'b0, count} + {{(QW+1){1'b0}}, inflight} - {{(QW+1){1'b0}}, pop};
    assign issue       = !reset && !redirect_valid && run_ok && occ < (QW+2)'(QDEPTH);
    assign rom_enable  = issue;
    assign rom_addr    = pc;
    assign instr_valid = count != '0;
    assign instr_data  = instr_valid ? qd[head] : '0;
    assign instr_pc    = instr_valid ? qp[head] : '0;

    // pc, in-flight tracking and queue pointers; reset and redirect both flush the queue
    always_ff @(posedge clk)
        if (reset || redirect_valid) begin
            pc       <= reset ? RESET_PC : target;
            inflight <= 1'b0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            if (issue) pc <= pc_next;
            inflight <= issue;
            ipc      <= pc;
            if (inflight) tail <= tail + 1'b1;
            if (pop) head <= head + 1'b1;
            count <= count + {{QW{1'b0}}, inflight} - {{QW{1'b0}}, pop};
        end

    // capture the returning word with its pc; occupancy accounting guarantees a free slot
    always_ff @(posedge clk)
        if (!reset && !redirect_valid && inflight) begin
            qd[tail] <= rom_data;
            qp[tail] <= ipc;
        end
endmodule

// File: tb/tb_rom_fetch.sv
// tb_rom_fetch: randomized scoreboard bench for rom_fetch (both ROM_BOUNDS_CHECK_EN builds).
module tb_rom_fetch;
    logic        clk = 1'b0;
    logic        reset, rom_enable, redirect_valid, instr_valid, instr_ready, fault;
    logic [31:0] rom_addr, rom_data, redirect_pc, instr_data, instr_pc;
    logic [7:0]  mem [128];
    logic [31:0] sb_pc [$];
    logic [31:0] sb_d [$];
    int checks = 0, fails = 0, deliveries = 0;

    always #5 clk = ~clk;

    rom_fetch dut (
        .clk(clk), .reset(reset), .rom_addr(rom_addr), .rom_enable(rom_enable),
        .rom_data(rom_data), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_data(instr_data), .instr_pc(instr_pc),
        .instr_ready(instr_ready), .fault(fault)
    );

    function automatic logic [31:0] word(input logic [31:0] a);
        logic [6:0] i = a[6:0];
        return {mem[i + 7'd3], mem[i + 7'd2], mem[i + 7'd1], mem[i]};
    endfunction

`ifdef ROM_BOUNDS_CHECK_EN
    function automatic logic legal(input logic [31:0] p);
        return p <= 32'd124 && p[1:0] == 2'b00;
    endfunction
    function automatic logic [31:0] nxt(input logic [31:0] p);
        return p + 32'd4;
    endfunction
    function automatic logic [31:0] tgt(input logic [31:0] r);
        return r;
    endfunction
`else
    function automatic logic [31:0] nxt(input logic [31:0] p);
        return (p + 32'd4) % 32'd128;
    endfunction
    function automatic logic [31:0] tgt(input logic [31:0] r);
        return {25'd0, r[6:2], 2'b00};
    endfunction
`endif

    // expected delivery stream after a reset/redirect: consecutive words from the start pc
    task automatic fill(input logic [31:0] start);
        logic [31:0] p = start;
        sb_pc.delete();
        sb_d.delete();
        for (int i = 0; i < 160; i++) begin
`ifdef ROM_BOUNDS_CHECK_EN
            if (!legal(p)) break;
`endif
            sb_pc.push_back(p);
            sb_d.push_back(word(p));
            p = nxt(p);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    // ROM: registered read, garbage when not enabled
    always @(posedge clk) rom_data <= rom_enable ? word(rom_addr) : 32'hDEADBEEF;

    // monitor: every accepted word must be the next expected (pc, data)
    always @(negedge clk)
        if (!reset && !redirect_valid && instr_valid && instr_ready) begin
            deliveries++;
            if (sb_pc.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL sb_underflow: got pc %h, expected no delivery", instr_pc);
            end else begin
                chk("deliver_pc", instr_pc, sb_pc.pop_front());
                chk("deliver_data", instr_data, sb_d.pop_front());
            end
        end

    initial begin
        logic [31:0] r;
        reset = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b0;
        for (int i = 0; i < 128; i++) mem[i] = i < 16 ? 8'(i) : 8'd0;
        tick(); tick(); samp();
        chk("rst_enable", rom_enable, 0);
        chk("rst_addr", rom_addr, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_data", instr_data, 0);
        chk("rst_pc", instr_pc, 0);
        chk("rst_fault", fault, 0);
        // streaming
        tick(); reset = 1'b0; instr_ready = 1'b1; fill(32'd0);
        samp();
        chk("c0_valid", instr_valid, 0);
        chk("c0_issue", rom_enable, 1);
        chk("c0_addr", rom_addr, 0);
        tick(); samp();
        chk("c1_valid", instr_valid, 0);
        for (int c = 2; c < 8; c++) begin
            tick(); samp();
            chk("stream_valid", instr_valid, 1);
        end
        // backpressure
        tick(); instr_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c != 0) tick();
            samp();
            chk("bp_no_issue", rom_enable, 0);
            chk("bp_valid", instr_valid, 1);
        end
        tick(); instr_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            samp();
        end
        // redirect with a read in flight and a pop in the same cycle
        tick(); redirect_valid = 1'b1; redirect_pc = 32'd8; fill(tgt(32'd8));
        samp();
        chk("rd_suppress", rom_enable, 0);
        tick(); redirect_valid = 1'b0;
        samp();
        chk("rd_t1_issue", rom_enable, 1);
        chk("rd_t1_addr", rom_addr, 8);
        chk("rd_t1_empty", instr_valid, 0);
        tick(); samp();
        chk("rd_t2_valid", instr_valid, 0);
        tick(); samp();
        chk("rd_t3_valid", instr_valid, 1);
        chk("rd_t3_pc", instr_pc, 8);
        for (int c = 0; c < 3; c++) tick();
        // top of ROM
        tick(); redirect_valid = 1'b1; redirect_pc = 32'd124; fill(tgt(32'd124));
        tick(); redirect_valid = 1'b0;
        samp();
        chk("top_t1_addr", rom_addr, 124);
        chk("top_t1_issue", rom_enable, 1);
        tick(); samp();
`ifdef ROM_BOUNDS_CHECK_EN
        chk("top_t2_no_issue", rom_enable, 0);
        chk("top_t2_fault", fault, 0);
`else
        chk("top_t2_wrap_addr", rom_addr, 0);
        chk("top_t2_issue", rom_enable, 1);
`endif
        tick(); samp();
        chk("top_t3_valid", instr_valid, 1);
        chk("top_t3_pc", instr_pc, 124);
`ifdef ROM_BOUNDS_CHECK_EN
        chk("top_t3_fault", fault, 1);
`endif
        tick(); samp();
`ifdef ROM_BOUNDS_CHECK_EN
        chk("fault_no_issue", rom_enable, 0);
        chk("fault_empty", instr_valid, 0);
        chk("fault_sticky", fault, 1);
`else
        chk("wrap_pc", instr_pc, 0);
`endif
        // misaligned redirect
        tick(); redirect_valid = 1'b1; redirect_pc = 32'd6; fill(tgt(32'd6));
        tick(); redirect_valid = 1'b0;
        samp();
        chk("mis_t1_fault", fault, 0);
`ifdef ROM_BOUNDS_CHECK_EN
        chk("mis_t1_no_issue", rom_enable, 0);
        tick(); samp();
        chk("mis_t2_fault", fault, 1);
`else
        chk("mis_t1_masked", rom_addr, 4);
        tick();
`endif
        // recovery
        tick(); redirect_valid = 1'b1; redirect_pc = 32'd0; fill(tgt(32'd0));
        tick(); redirect_valid = 1'b0;
        samp();
        chk("rec_fault", fault, 0);
        chk("rec_issue", rom_enable, 1);
        tick(); tick(); samp();
        chk("rec_valid", instr_valid, 1);
        chk("rec_pc", instr_pc, 0);
        for (int c = 0; c < 3; c++) tick();
        // reset mid-stream
        tick(); reset = 1'b1; fill(32'd0);
        samp();
        chk("mrst_no_issue", rom_enable, 0);
        tick(); reset = 1'b0;
        samp();
        chk("mrst_valid", instr_valid, 0);
        chk("mrst_data", instr_data, 0);
        chk("mrst_pc", instr_pc, 0);
        chk("mrst_fault", fault, 0);
        chk("mrst_addr", rom_addr, 0);
        chk("mrst_issue", rom_enable, 1);
        tick(); samp();
        chk("mrst_c1_valid", instr_valid, 0);
        tick(); samp();
        chk("mrst_c2_valid", instr_valid, 1);
        // randomized traffic over a random ROM image
        tick(); reset = 1'b1;
        for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
        fill(32'd0);
        for (int c = 0; c < 400; c++) begin
            tick();
            reset = 1'b0;
            redirect_valid = 1'b0;
            instr_ready = $urandom_range(0, 3) != 0;
            r = 32'($urandom_range(0, 29));
            if (r == 0) begin
                reset = 1'b1;
                fill(32'd0);
            end else if (r <= 2) begin
`ifdef ROM_BOUNDS_CHECK_EN
                redirect_pc = $urandom_range(0, 9) == 0 ? 32'($urandom_range(0, 200))
                                                        : 32'($urandom_range(0, 31)) * 32'd4;
`else
                redirect_pc = $urandom;
`endif
                redirect_valid = 1'b1;
                fill(tgt(redirect_pc));
            end
        end
        tick(); reset = 1'b0; redirect_valid = 1'b0; instr_ready = 1'b1;
        tick(); samp();
        chk("deliveries_seen", 32'(deliveries >= 100), 1);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
